// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM model.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // instruction side
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    // data side
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    // RAM side
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    // Arbiter view.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Requester/RAM environment view.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data side has priority, a streak counter bounds
// how long a pending fetch can be starved by back-to-back data grants.
module memory_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input logic              CLK,
    input logic              RST,
    memory_arbiter_if.slave  bus
);
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          dreq;

    assign dreq = bus.dREN | bus.dWEN;

    // State and streak registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    // Grant decision and access termination.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        unique case (state_q)
            StIdle: begin
                // Data wins unless a waiting fetch has already been passed over MAX times.
                if (dreq && !(bus.iREN && dstreak_q == MAX_S)) begin
                    state_d = StDacc;
                    if (bus.iREN) begin
                        dstreak_d = (dstreak_q == MAX_S) ? MAX_S : dstreak_q + SW'(1);
                    end else begin
                        dstreak_d = '0;
                    end
                end else if (bus.iREN) begin
                    state_d   = StIacc;
                    dstreak_d = '0;
                end
            end
            StIacc: begin
                if (!bus.iREN || bus.ramready) state_d = StIdle;
            end
            StDacc: begin
                if (!dreq || bus.ramready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // RAM strobes from state; hits and return data qualified by ramready.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        bus.ihit     = 1'b0;
        bus.iload    = {DATA_W{1'b0}};
        bus.dhit     = 1'b0;
        bus.dload    = {DATA_W{1'b0}};
        unique case (state_q)
            StIacc: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.ihit    = bus.ramready;
                if (bus.ramready) bus.iload = bus.ramload;
            end
            StDacc: begin
                bus.ramaddr = bus.daddr;
                bus.dhit    = bus.ramready;
                // Write takes precedence when both read and write are requested.
                if (bus.dWEN) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore;
                end else begin
                    bus.ramREN = 1'b1;
                    if (bus.ramready) bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, fetch, data priority, starvation
// bound, write path, and reset in the middle of a data access.
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] grant_addr [6];
    logic        grant_is_d [6];

    initial begin
        grant_addr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h40, 32'h100};
        grant_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        bus.ramload = 32'h0; bus.ramready = 1'b0;

        // Reset held two edges with a fetch pending.
        tick(); tick();
        #1;
        check("rst_ramREN", {31'b0, bus.ramREN}, 32'h0);
        check("rst_ihit", {31'b0, bus.ihit}, 32'h0);
        check("rst_ramaddr", bus.ramaddr, 32'h0);

        // Release: fetch granted at next edge, ready on second IACC cycle.
        rst = 1'b0;
        tick(); #1;
        check("i_grant_ramREN", {31'b0, bus.ramREN}, 32'h1);
        check("i_grant_ramaddr", bus.ramaddr, 32'h40);
        check("i_wait_ihit", {31'b0, bus.ihit}, 32'h0);
        tick();
        bus.ramready = 1'b1; bus.ramload = 32'hDEADBEEF;
        #1;
        check("i_hit_ihit", {31'b0, bus.ihit}, 32'h1);
        check("i_hit_iload", bus.iload, 32'hDEADBEEF);
        check("i_hit_ramaddr", bus.ramaddr, 32'h40);
        tick();
        bus.iREN = 1'b0; bus.ramready = 1'b0;
        #1;
        check("i_idle_ramREN", {31'b0, bus.ramREN}, 32'h0);
        check("i_idle_iload", bus.iload, 32'h0);

        // Simultaneous fetch and read: data first, one idle cycle, then fetch.
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100;
        tick(); #1;
        check("prio_d_ramaddr", bus.ramaddr, 32'h100);
        check("prio_d_ramREN", {31'b0, bus.ramREN}, 32'h1);
        check("prio_d_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
        bus.ramready = 1'b1; bus.ramload = 32'hCAFEF00D;
        #1;
        check("prio_dhit", {31'b0, bus.dhit}, 32'h1);
        check("prio_dload", bus.dload, 32'hCAFEF00D);
        check("prio_no_ihit", {31'b0, bus.ihit}, 32'h0);
        tick();
        bus.dREN = 1'b0; bus.ramready = 1'b0;
        #1;
        check("prio_gap_ramREN", {31'b0, bus.ramREN}, 32'h0);
        tick(); #1;
        check("prio_i_ramaddr", bus.ramaddr, 32'h40);
        check("prio_i_ramREN", {31'b0, bus.ramREN}, 32'h1);
        bus.ramready = 1'b1;
        #1;
        check("prio_ihit", {31'b0, bus.ihit}, 32'h1);
        tick();
        bus.ramready = 1'b0;

        // Starvation bound: fetch held, read kept asserted -> D,D,D,D,I,D.
        bus.dREN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            check($sformatf("streak%0d_ramaddr", i), bus.ramaddr, grant_addr[i]);
            bus.ramready = 1'b1;
            #1;
            check($sformatf("streak%0d_dhit", i), {31'b0, bus.dhit}, {31'b0, grant_is_d[i]});
            check($sformatf("streak%0d_ihit", i), {31'b0, bus.ihit}, {31'b0, ~grant_is_d[i]});
            tick();
            bus.ramready = 1'b0;
            #1;
            check($sformatf("streak%0d_idle", i), {31'b0, bus.ramREN}, 32'h0);
        end

        // Write (with dREN also set): write wins, no load data returned.
        bus.iREN = 1'b0; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        tick(); #1;
        check("wr_ramWEN", {31'b0, bus.ramWEN}, 32'h1);
        check("wr_ramREN", {31'b0, bus.ramREN}, 32'h0);
        check("wr_ramstore", bus.ramstore, 32'h1234);
        check("wr_ramaddr", bus.ramaddr, 32'h80);
        bus.ramready = 1'b1; bus.ramload = 32'h5555AAAA;
        #1;
        check("wr_dhit", {31'b0, bus.dhit}, 32'h1);
        check("wr_dload", bus.dload, 32'h0);
        tick();
        bus.dWEN = 1'b0; bus.ramready = 1'b0;
        #1;
        check("wr_idle_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
        check("wr_idle_ramstore", bus.ramstore, 32'h0);

        // Build streak to 3, then reset during the fourth data access.
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.ramready = 1'b1;
            tick();
            bus.ramready = 1'b0;
        end
        tick(); #1;
        check("rst_mid_in_dacc", bus.ramaddr, 32'h100);
        rst = 1'b1;
        tick();
        bus.ramready = 1'b1;
        #1;
        check("rst_mid_ramREN", {31'b0, bus.ramREN}, 32'h0);
        check("rst_mid_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
        check("rst_mid_dhit", {31'b0, bus.dhit}, 32'h0);
        rst = 1'b0; bus.ramready = 1'b0;
        // Streak cleared by reset, so data is granted again despite pending fetch.
        tick(); #1;
        check("rst_mid_streak_clr", bus.ramaddr, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
